// File: rtl/dmem_sched_pkg.sv
// Shared types for the dmem access scheduler.
// Engine state encoding and vector geometry.
package dmem_sched_pkg;

  localparam int VEC_S = 32;
  localparam int VEC_V = 192;
  localparam int WORDS_PER_VEC = VEC_V / VEC_S;
  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL,
    DRAIN
  } eng_state_t;

endpackage

// File: rtl/dmem_access_sched_if.sv
// Core-side access bus and stream output bundle.
// slave = scheduler view, master = driver/sink view.
interface dmem_sched_if #(
  parameter int S = 32,
  parameter int V = 192
);
  logic         core_req;
  logic         core_we;
  logic         core_isVector;
  logic [S-1:0] core_address;
  logic [V-1:0] core_wd;
  logic         core_gnt;
  logic [V-1:0] core_rd;
  logic         out_valid;
  logic         out_ready;
  logic [V-1:0] out_data;
  logic [2:0]   out_words;
  logic         out_last;

  modport slave (
    input  core_req, core_we, core_isVector,
    input  core_address, core_wd, out_ready,
    output core_gnt, core_rd, out_valid,
    output out_data, out_words, out_last
  );

  modport master (
    output core_req, core_we, core_isVector,
    output core_address, core_wd, out_ready,
    input  core_gnt, core_rd, out_valid,
    input  out_data, out_words, out_last
  );
endinterface

// File: rtl/dmem_access_sched_sync_2ff.sv
// Two-flop synchronizer for the dump switch.
// rise pulses for one cycle on a synchronized 0->1 edge.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
endmodule

// File: rtl/dmem_access_sched.sv
// Data-memory port scheduler: core access plus image-dump stream engine.
// DMEM_SCHED_STATS_EN adds stat_forced / stat_chunks counters.
module dmem_access_sched
  import dmem_sched_pkg::*;
#(
  parameter int S          = 32,
  parameter int V          = 192,
  parameter int IMG_BASE   = 0,
  parameter int IMG_WORDS  = 30000,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_sched_if.slave  bus,
  output logic         mem_we,
  output logic         mem_isVector,
  output logic [S-1:0] mem_address,
  output logic [V-1:0] mem_wd,
  input  logic [V-1:0] mem_rd,
  input  logic         start_i,
  output logic         busy
`ifdef DMEM_SCHED_STATS_EN
  ,
  output logic [CHUNK_W-1:0] stat_forced,
  output logic [CHUNK_W-1:0] stat_chunks
`endif
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  eng_state_t   state_q, state_d;
  logic [S-1:0] addr_q;
  logic [S-1:0] rem_q;
  logic [SW-1:0] starve_q;
  logic [V-1:0] buf_q;
  logic         start_rise;
  logic         fetch, force_slot, eng_win, accept, go;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (start_i),
    .rise (start_rise)
  );

  assign fetch      = state_q == FETCH;
  assign force_slot = fetch && starve_q == SW'(STARVE_MAX);
  assign bus.core_gnt = bus.core_req && !force_slot;
  assign eng_win    = fetch && !bus.core_gnt;
  assign accept     = state_q == DRAIN && bus.out_ready;
  assign go         = state_q == IDLE && start_rise;

  assign busy          = state_q != IDLE;
  assign bus.core_rd   = mem_rd;
  assign bus.out_valid = state_q == DRAIN;
  assign bus.out_data  = buf_q;
  assign bus.out_words = (rem_q >= S'(WORDS_PER_VEC))
                       ? 3'(WORDS_PER_VEC) : rem_q[2:0];
  assign bus.out_last  = state_q == DRAIN
                       && rem_q <= S'(WORDS_PER_VEC);

  always_comb begin
    mem_we       = 1'b0;
    mem_isVector = 1'b0;
    mem_address  = '0;
    mem_wd       = '0;
    if (bus.core_gnt) begin
      mem_we       = bus.core_we;
      mem_isVector = bus.core_isVector;
      mem_address  = bus.core_address;
      mem_wd       = bus.core_wd;
    end else if (fetch) begin
      mem_isVector = 1'b1;
      mem_address  = addr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_rise) state_d = FETCH;
      FETCH:   if (eng_win) state_d = FILL;
      FILL:    state_d = DRAIN;
      DRAIN:   if (accept) state_d = bus.out_last ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= S'(IMG_BASE);
      rem_q    <= '0;
      starve_q <= '0;
      buf_q    <= '0;
    end else begin
      if (go) begin
        addr_q   <= S'(IMG_BASE);
        rem_q    <= S'(IMG_WORDS);
        starve_q <= '0;
      end
      // a forced slot always wins, so the counter never passes STARVE_MAX
      if (fetch) starve_q <= eng_win ? '0 : starve_q + 1'b1;
      if (eng_win) buf_q <= mem_rd;
      if (accept) begin
        addr_q <= addr_q + S'(WORDS_PER_VEC);
        rem_q  <= rem_q - S'(bus.out_words);
      end
    end
  end

`ifdef DMEM_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_forced <= '0;
      stat_chunks <= '0;
    end else if (go) begin
      stat_forced <= '0;
      stat_chunks <= '0;
    end else begin
      if (force_slot && stat_forced != '1)
        stat_forced <= stat_forced + 1'b1;
      if (accept && stat_chunks != '1)
        stat_chunks <= stat_chunks + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_access_sched.sv
// Scoreboard bench for dmem_access_sched with a 64-word RAM model.
// Small image (14 words) so chunks are 6, 6, 2.
module tb_dmem_access_sched;
  localparam int S = 32;
  localparam int V = 192;

  logic clk = 1'b0;
  logic rst_n;
  logic start_i;
  logic mem_we, mem_isVector;
  logic [S-1:0] mem_address;
  logic [V-1:0] mem_wd, mem_rd;
  logic busy;

  dmem_sched_if #(.S(S), .V(V)) bus ();

  dmem_access_sched #(
    .S(S), .V(V), .IMG_BASE(0),
    .IMG_WORDS(14), .STARVE_MAX(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_we      (mem_we),
    .mem_isVector(mem_isVector),
    .mem_address (mem_address),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd),
    .start_i     (start_i),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [64];
  logic init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h1000 + i;
      init_done <= 1'b1;
    end else if (mem_we) begin
      for (int w = 0; w < 6; w++)
        if (w == 0 || mem_isVector)
          ram[(int'(mem_address) + w) % 64] <= mem_wd[w*32 +: 32];
    end
  end

  always_comb begin
    mem_rd = '0;
    for (int w = 0; w < 6; w++)
      if (w == 0 || mem_isVector)
        mem_rd[w*32 +: 32] = ram[(int'(mem_address) + w) % 64];
  end

  typedef struct {
    logic [V-1:0] d;
    logic [2:0]   n;
    logic         l;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;
  int popped = 0;

  function automatic logic [V-1:0] pat(int b);
    logic [V-1:0] r;
    r = '0;
    for (int w = 0; w < 6; w++) r[w*32 +: 32] = 32'h1000 + b + w;
    return r;
  endfunction

  task automatic chk(string name, logic [V-1:0] act, logic [V-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(logic [V-1:0] d, logic [2:0] n, logic l);
    exp_t e;
    e.d = d;
    e.n = n;
    e.l = l;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow act=chunk exp=none");
      end else begin
        exp_t e;
        logic [V-1:0] m;
        e = sbq.pop_front();
        m = '0;
        for (int w = 0; w < 6; w++)
          if (w < int'(e.n)) m[w*32 +: 32] = '1;
        chk("chunk_data", bus.out_data & m, e.d & m);
        chk("chunk_words", V'(bus.out_words), V'(e.n));
        chk("chunk_last", V'(bus.out_last), V'(e.l));
      end
      popped++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(string name);
    int c;
    c = 0;
    @(negedge clk);
    while (!busy && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk(name, V'(busy), V'(1));
  endtask

  task automatic wait_idle(string name);
    int c;
    c = 0;
    @(negedge clk);
    while (busy && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(name, V'(busy), V'(0));
  endtask

  task automatic core_idle();
    bus.core_req      = 1'b0;
    bus.core_we       = 1'b0;
    bus.core_isVector = 1'b0;
    bus.core_address  = '0;
    bus.core_wd       = '0;
  endtask

  task automatic push_full();
    push(pat(0), 3'd6, 1'b0);
    push(pat(6), 3'd6, 1'b0);
    push(pat(12), 3'd2, 1'b1);
  endtask

  initial begin
    int lows, highs, first, errs, miss, c;
    logic [V-1:0] hold_d;
    logic [2:0]   hold_n;

    rst_n = 1'b0;
    start_i = 1'b0;
    bus.out_ready = 1'b0;
    core_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", V'(bus.out_valid), V'(0));
    chk("rst_busy", V'(busy), V'(0));
    chk("rst_core_gnt", V'(bus.core_gnt), V'(0));
    chk("rst_mem_we", V'(mem_we), V'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // plain dump, no core traffic
    bus.out_ready = 1'b1;
    push_full();
    start_i = 1'b1;
    wait_busy("t2_busy_rise");
    start_i = 1'b0;
    wait_idle("t2_busy_clear");
    chk("t2_sb_empty", V'(sbq.size()), V'(0));
    chk("t2_popped", V'(popped), V'(3));

    // core read held high during a dump
    tick();
    bus.core_req = 1'b1;
    bus.core_isVector = 1'b1;
    bus.core_address = 32'd40;
    @(negedge clk);
    chk("t3_core_rd", mem_rd == pat(40) ? bus.core_rd : ~bus.core_rd, pat(40));
    chk("t3_core_gnt_idle", V'(bus.core_gnt), V'(1));
    push_full();
    start_i = 1'b1;
    wait_busy("t3_busy_rise");
    start_i = 1'b0;
    lows = 0;
    highs = 0;
    first = -1;
    c = 0;
    while (busy && c < 400) begin
      if (!bus.core_gnt) begin
        if (lows == 0) first = highs;
        lows++;
      end else highs++;
      @(negedge clk);
      c++;
    end
    chk("t3_done", V'(busy), V'(0));
    chk("t3_first_force", V'(first), V'(8));
    chk("t3_forced_slots", V'(lows), V'(3));
    chk("t3_sb_empty", V'(sbq.size()), V'(0));

    // sink stalls for 20 cycles in DRAIN
    tick();
    bus.out_ready = 1'b0;
    push_full();
    start_i = 1'b1;
    wait_busy("t4_busy_rise");
    start_i = 1'b0;
    c = 0;
    while (!bus.out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t4_valid", V'(bus.out_valid), V'(1));
    hold_d = bus.out_data;
    hold_n = bus.out_words;
    errs = 0;
    miss = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_data !== hold_d
          || bus.out_words !== hold_n) errs++;
      if (!bus.core_gnt || mem_address !== 32'd40) miss++;
    end
    chk("t4_stable", V'(errs), V'(0));
    chk("t4_core_owns_port", V'(miss), V'(0));
    chk("t4_held_data", hold_d, pat(0));
    tick();
    bus.out_ready = 1'b1;
    wait_idle("t4_busy_clear");
    chk("t4_sb_empty", V'(sbq.size()), V'(0));

    // core writes the chunk the engine is fetching
    tick();
    core_idle();
    push(pat(0), 3'd6, 1'b0);
    push({6{32'h0000_00A5}}, 3'd6, 1'b0);
    push(pat(12), 3'd2, 1'b1);
    start_i = 1'b1;
    wait_busy("t5_busy_rise");
    start_i = 1'b0;
    c = 0;
    while (!(busy && mem_isVector && mem_address == 32'd6)
           && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t5_fetch6_seen", V'(mem_address), V'(6));
    bus.core_req = 1'b1;
    bus.core_we = 1'b1;
    bus.core_isVector = 1'b1;
    bus.core_address = 32'd6;
    bus.core_wd = {6{32'h0000_00A5}};
    #1;
    chk("t5_core_wins", V'(bus.core_gnt), V'(1));
    tick();
    core_idle();
    wait_idle("t5_busy_clear");
    chk("t5_sb_empty", V'(sbq.size()), V'(0));
    tick();
    bus.core_req = 1'b1;
    bus.core_we = 1'b1;
    bus.core_isVector = 1'b1;
    bus.core_address = 32'd6;
    bus.core_wd = pat(6);
    tick();
    core_idle();

    // reset mid-dump, then restart
    bus.out_ready = 1'b0;
    push(pat(0), 3'd6, 1'b0);
    start_i = 1'b1;
    wait_busy("t6_busy_rise");
    start_i = 1'b0;
    c = 0;
    while (!bus.out_valid && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t6_valid_before", V'(bus.out_valid), V'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_async", V'(bus.out_valid), V'(0));
    chk("t6_busy_async", V'(busy), V'(0));
    sbq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    push_full();
    start_i = 1'b1;
    wait_busy("t6_restart");
    start_i = 1'b0;
    wait_idle("t6_busy_clear");
    chk("t6_sb_empty", V'(sbq.size()), V'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
